bg_mem_arbiter: RTL
===================

Name: bg_mem_arbiter

Overview:
- Shares the single-port 12-bit background frame memory (160x120 words) between two requesters:
  - VGA pixel fetch, which has absolute priority.
  - A game-logic writer that updates background tiles.
- Generates the scaled fetch address from h_cnt/v_cnt and latches returned colour for the display mux.
- Sits between the VGA timing generator, the game-logic update path and the block memory instance.

Parameters:
- H_W, 160, stored image width in words
- V_H, 120, stored image height in words
- AW, 15, memory address width
- DW, 12, pixel width (RGB444)
- SHIFT, 2, screen-to-memory downscale shift (each word covers 4x4 screen pixels)
- RD_LAT, 1, memory read latency in clk cycles; legal values 1..2

Ports:
- clk  in  1  pixel clock (25 MHz); the only clock
- rst  in  1  synchronous, active-low reset
- h_cnt  in  10  VGA horizontal counter
- v_cnt  in  10  VGA vertical counter
- valid  in  1  display-active flag
- pix_out  out  DW  background colour to display mux
- mem_addr  out  AW  memory address
- mem_we  out  1  memory write enable
- mem_din  out  DW  memory write data
- mem_dout  in  DW  memory read data
- wr_req  in  1  writer request; held until acked
- wr_addr  in  AW  writer address
- wr_data  in  DW  writer data
- wr_ack  out  1  one-cycle grant pulse

Behaviour:
- Reset (rst==0 at a clk edge):
  - pix_out=0, wr_ack=0, mem_we=0, mem_addr=0, mem_din=0.
  - Read-issue history cleared; in-flight captures discarded; FSM to IDLE.
- VGA read slot: valid==1 and h_cnt[1:0]==0.
  - mem_addr = (h_cnt>>SHIFT) + H_W*(v_cnt>>SHIFT), computed at AW width. Output is combinational from the counters in that cycle.
  - mem_we=0.
- Read capture:
  - mem_dout is sampled RD_LAT cycles after issue into a pixel latch. pix_out is the latch.
  - pix_out is forced 0 when valid delayed by RD_LAT+1 is 0.
  - Total pixel latency is RD_LAT+1 cycles; the top level delays hsync/vsync to match.
  - Latch holds for the 4-cycle group.
- Write-allowed cycle: no VGA read in this cycle and none in the previous RD_LAT-1 cycles. This is tracked by a read-issue shift register, so a pipelined read is never corrupted.
- Writer handshake:
  - In a write-allowed cycle with wr_req=1 (FSM IDLE): wr_ack=1 and mem_addr=wr_addr, mem_din=wr_data, all in the same cycle.
  - mem_we=1 if wr_addr<H_W*V_H, else mem_we=0 (ack still given, write dropped).
  - wr_req still high in the next cycle is a new transaction.
- Blanking (valid=0): every cycle is write-allowed once the history drains, giving 1 write per cycle.
- Simultaneous VGA slot and wr_req: VGA wins; writer waits; no ack.
- FSM states:
  - IDLE: normal arbitration.
  - CLEAR: only with the optional feature.

Optional Feature:
- Macro BG_CLEAR_EN.
- With the macro: extra ports clr_start (in, 1), clr_color (in, DW), clr_busy (out, 1).
  - clr_start in IDLE latches clr_color and enters CLEAR; clr_busy=1.
  - CLEAR writes addresses 0..H_W*V_H-1 in ascending order, one per write-allowed cycle. Writer is never acked during CLEAR.
  - After address 19199 is written, return to IDLE; clr_busy=0 in the next cycle.
  - clr_start during CLEAR is ignored.
  - Reset mid-clear: IDLE, counter 0, clr_busy 0.
- Without the macro: ports absent; FSM permanently IDLE.

Decomposition:
- Package bg_pkg holds: H_W, V_H, BG_DEPTH=19200, AW, DW, SHIFT, and the state enum {ST_IDLE, ST_CLEAR}.
- One sub-module, bg_vga_fetch, holds:
  - address calculation
  - read-slot detect
  - read-issue shift register
  - capture latch
  - delayed valid
- It exports rd_slot and wr_allowed to the arbiter.

Test Plan:
- Reset: rst=0 for 3 cycles during active writer traffic -> pix_out=0, wr_ack=0, mem_we=0; first ack no earlier than 1 cycle after release.
- Fetch: valid=1, h_cnt=8, v_cnt=4 -> mem_addr=162, mem_we=0. Model returns 12'hABC -> pix_out=12'hABC at cycle 10 (RD_LAT=1), held through cycle 13.
- Contention: wr_req addr 100, data 12'h0F0 asserted at h_cnt=4, valid=1 -> no ack at h_cnt=4. wr_ack, mem_we=1, mem_addr=100 at h_cnt=5 (RD_LAT=1); at h_cnt=6 with RD_LAT=2.
- Range: wr_addr=19200 in blanking -> wr_ack=1, mem_we=0.
- Blanking throughput: valid=0, wr_req held 8 cycles with changing addresses -> 8 consecutive acks and writes.
- Clear (BG_CLEAR_EN): clr_start, clr_color=12'h000, valid=0 -> clr_busy high exactly 19200 cycles, addresses 0..19199 written once each; concurrent wr_req unacked until clr_busy falls.

Source files
------------

// File: rtl/bg_pkg.sv
// Shared constants, FSM state type and helpers for the background memory arbiter.
package bg_pkg;

  localparam int H_W      = 160;          // stored image width in words
  localparam int V_H      = 120;          // stored image height in words
  localparam int BG_DEPTH = H_W * V_H;    // 19200 words
  localparam int AW       = 15;           // memory address width
  localparam int DW       = 12;           // RGB444 pixel width
  localparam int SHIFT    = 2;            // each word covers 4x4 screen pixels

  localparam logic [AW-1:0] LAST_ADDR = AW'(BG_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } bg_state_e;

  // True when a writer address lands inside the stored frame.
  function automatic logic addr_in_range(input logic [AW-1:0] addr);
    return (addr < AW'(BG_DEPTH));
  endfunction

endpackage

// File: rtl/bg_mem_arbiter_if.sv
// Writer handshake plus single-port memory bus seen by the arbiter.
// slave  : the arbiter side (receives requests, drives the memory).
// master : the environment side (writer logic and the block memory).
interface bg_mem_arbiter_if
  import bg_pkg::*;
;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  wr_req, wr_addr, wr_data, mem_dout,
    output wr_ack, mem_addr, mem_we, mem_din
  );

  modport master (
    output wr_req, wr_addr, wr_data, mem_dout,
    input  wr_ack, mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/bg_vga_fetch.sv
// VGA side of the background memory: scaled fetch address, read-slot
// detection, read-issue history (decides when the port is free for writes),
// returned-colour latch and the delayed display-active flag that blanks it.
module bg_vga_fetch
  import bg_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    h_cnt,
  input  logic [9:0]    v_cnt,
  input  logic          valid,
  input  logic [DW-1:0] mem_dout,
  output logic          rd_slot,
  output logic          wr_allowed,
  output logic [AW-1:0] rd_addr,
  output logic [DW-1:0] pix_out
);

  localparam int VW = RD_LAT + 1;
  // History bits that still cover an in-flight read (all but the oldest).
  localparam logic [RD_LAT-1:0] HIST_MASK = RD_LAT'((1 << (RD_LAT - 1)) - 1);

  logic [RD_LAT-1:0] rd_hist_q, rd_hist_d;
  logic [VW-1:0]     vld_q, vld_d;
  logic [DW-1:0]     pix_q, pix_d;

  // Read slot once per 4-pixel group, its word address, and the write window.
  always_comb begin
    rd_slot    = valid && (h_cnt[1:0] == 2'b00);
    rd_addr    = AW'(h_cnt >> SHIFT) + (AW'(H_W) * AW'(v_cnt >> SHIFT));
    wr_allowed = !rd_slot && ((rd_hist_q & HIST_MASK) == {RD_LAT{1'b0}});
  end

  // Shift histories; capture memory data RD_LAT cycles after the read issued.
  always_comb begin
    rd_hist_d = RD_LAT'({rd_hist_q, rd_slot});
    vld_d     = VW'({vld_q, valid});
    if (rd_hist_q[RD_LAT-1]) begin
      pix_d = mem_dout;
    end else begin
      pix_d = pix_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_hist_q <= {RD_LAT{1'b0}};
      vld_q     <= {VW{1'b0}};
      pix_q     <= {DW{1'b0}};
    end else begin
      rd_hist_q <= rd_hist_d;
      vld_q     <= vld_d;
      pix_q     <= pix_d;
    end
  end

  // Blank the latch whenever the matching display-active flag was low.
  always_comb begin
    if (vld_q[RD_LAT]) begin
      pix_out = pix_q;
    end else begin
      pix_out = {DW{1'b0}};
    end
  end

endmodule

// File: rtl/bg_mem_arbiter.sv
// Background frame memory arbiter: VGA pixel fetch has absolute priority,
// game-logic writes use the remaining write-allowed cycles.
// Optional feature (macro BG_CLEAR_EN): full-frame clear engine with
// clr_start / clr_color / clr_busy ports; without it the FSM stays in IDLE.
module bg_mem_arbiter
  import bg_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    h_cnt,
  input  logic [9:0]    v_cnt,
  input  logic          valid,
  output logic [DW-1:0] pix_out,
`ifdef BG_CLEAR_EN
  input  logic          clr_start,
  input  logic [DW-1:0] clr_color,
  output logic          clr_busy,
`endif
  bg_mem_arbiter_if.slave bus
);

  bg_state_e     state_q, state_d;
  logic          rd_slot_s;
  logic          wr_allowed_s;
  logic [AW-1:0] rd_addr_s;
  logic [AW-1:0] mem_addr_s;
  logic          mem_we_s;
  logic [DW-1:0] mem_din_s;
  logic          wr_ack_s;
`ifdef BG_CLEAR_EN
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [DW-1:0] clr_color_q, clr_color_d;
`endif

  bg_vga_fetch #(.RD_LAT(RD_LAT)) u_fetch (
    .clk        (clk),
    .rst        (rst),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .valid      (valid),
    .mem_dout   (bus.mem_dout),
    .rd_slot    (rd_slot_s),
    .wr_allowed (wr_allowed_s),
    .rd_addr    (rd_addr_s),
    .pix_out    (pix_out)
  );

  // Port arbitration and next-state; everything idles to zero in reset.
  always_comb begin
    state_d    = state_q;
`ifdef BG_CLEAR_EN
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
`endif
    mem_addr_s = {AW{1'b0}};
    mem_we_s   = 1'b0;
    mem_din_s  = {DW{1'b0}};
    wr_ack_s   = 1'b0;
    if (!rst) begin
      state_d = ST_IDLE;
    end else begin
      if (rd_slot_s) begin
        mem_addr_s = rd_addr_s;
      end else begin
        mem_addr_s = {AW{1'b0}};
      end
      case (state_q)
        ST_IDLE: begin
          if (wr_allowed_s && bus.wr_req) begin
            wr_ack_s   = 1'b1;
            mem_addr_s = bus.wr_addr;
            mem_din_s  = bus.wr_data;
            mem_we_s   = addr_in_range(bus.wr_addr);
          end else begin
            wr_ack_s = 1'b0;
          end
`ifdef BG_CLEAR_EN
          if (clr_start) begin
            state_d     = ST_CLEAR;
            clr_color_d = clr_color;
            clr_cnt_d   = {AW{1'b0}};
          end else begin
            state_d = ST_IDLE;
          end
`endif
        end
        ST_CLEAR: begin
`ifdef BG_CLEAR_EN
          // Writer is starved here; clr_start is ignored.
          if (wr_allowed_s) begin
            mem_addr_s = clr_cnt_q;
            mem_din_s  = clr_color_q;
            mem_we_s   = 1'b1;
            if (clr_cnt_q == LAST_ADDR) begin
              state_d   = ST_IDLE;
              clr_cnt_d = {AW{1'b0}};
            end else begin
              clr_cnt_d = clr_cnt_q + AW'(1);
            end
          end else begin
            state_d = ST_CLEAR;
          end
`else
          state_d = ST_IDLE;
`endif
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM and clear-engine registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
`ifdef BG_CLEAR_EN
      clr_cnt_q   <= {AW{1'b0}};
      clr_color_q <= {DW{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
`ifdef BG_CLEAR_EN
      clr_cnt_q   <= clr_cnt_d;
      clr_color_q <= clr_color_d;
`endif
    end
  end

  assign bus.mem_addr = mem_addr_s;
  assign bus.mem_we   = mem_we_s;
  assign bus.mem_din  = mem_din_s;
  assign bus.wr_ack   = wr_ack_s;
`ifdef BG_CLEAR_EN
  assign clr_busy     = (state_q == ST_CLEAR);
`endif

endmodule
